// File: rtl/tl_arb2_if.sv
// Single-beat TileLink bundle shared by the arbiter's master-facing and slave-facing ports.
// The "master" modport drives the A channel and d_ready; "slave" drives a_ready and the D channel.
interface tl_arb2_if #(
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int SRCW = 4
);
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      a_opcode;
    logic [2:0]      a_size;
    logic [SRCW-1:0] a_source;
    logic [AW-1:0]   a_address;
    logic [DW-1:0]   a_data;
    logic [DW/8-1:0] a_mask;
    logic            a_corrupt;

    logic            d_valid;
    logic            d_ready;
    logic [2:0]      d_opcode;
    logic [2:0]      d_size;
    logic [SRCW-1:0] d_source;
    logic [DW-1:0]   d_data;
    logic            d_denied;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        input  d_ready
    );
endinterface

// File: rtl/tl_arb2.sv
// Two-master round-robin arbiter in front of a single-outstanding TileLink slave.
// A watchdog answers a stalled request with a denied beat, then drains the slave's late beat.
module tl_arb2 #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int SRCW    = 4
) (
    input  logic      clk,
    input  logic      rst,
    tl_arb2_if.slave  m0,
    tl_arb2_if.slave  m1,
    tl_arb2_if.master s
);
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, TOUT, DRAIN} state_e;

    state_e          state_q, state_d;
    logic            g_q, g_d;
    logic            p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      cap_op_q, cap_op_d;
    logic [2:0]      cap_size_q, cap_size_d;
    logic [SRCW-1:0] cap_src_q, cap_src_d;

    // Granted master's A channel and d_ready
    logic            sel_a_valid;
    logic [2:0]      sel_a_opcode;
    logic [2:0]      sel_a_size;
    logic [SRCW-1:0] sel_a_source;
    logic [AW-1:0]   sel_a_address;
    logic [DW-1:0]   sel_a_data;
    logic [DW/8-1:0] sel_a_mask;
    logic            sel_a_corrupt;
    logic            sel_d_ready;

    // Response heading to the granted master, before per-master gating
    logic            gnt_a_ready;
    logic            rsp_valid;
    logic [2:0]      rsp_op;
    logic [2:0]      rsp_size;
    logic [SRCW-1:0] rsp_src;
    logic [DW-1:0]   rsp_data;
    logic            rsp_denied;
    logic            rsp0, rsp1;

    always_comb begin
        sel_a_valid   = g_q ? m1.a_valid   : m0.a_valid;
        sel_a_opcode  = g_q ? m1.a_opcode  : m0.a_opcode;
        sel_a_size    = g_q ? m1.a_size    : m0.a_size;
        sel_a_source  = g_q ? m1.a_source  : m0.a_source;
        sel_a_address = g_q ? m1.a_address : m0.a_address;
        sel_a_data    = g_q ? m1.a_data    : m0.a_data;
        sel_a_mask    = g_q ? m1.a_mask    : m0.a_mask;
        sel_a_corrupt = g_q ? m1.a_corrupt : m0.a_corrupt;
        sel_d_ready   = g_q ? m1.d_ready   : m0.d_ready;
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        cap_op_d   = cap_op_q;
        cap_size_d = cap_size_q;
        cap_src_d  = cap_src_q;

        s.a_valid   = 1'b0;
        s.a_opcode  = '0;
        s.a_size    = '0;
        s.a_source  = '0;
        s.a_address = '0;
        s.a_data    = '0;
        s.a_mask    = '0;
        s.a_corrupt = 1'b0;
        s.d_ready   = 1'b0;

        gnt_a_ready = 1'b0;
        rsp_valid   = 1'b0;
        rsp_op      = '0;
        rsp_size    = '0;
        rsp_src     = '0;
        rsp_data    = '0;
        rsp_denied  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0.a_valid && m1.a_valid) g_d = p_q;
                else if (m1.a_valid)          g_d = 1'b1;
                else if (m0.a_valid)          g_d = 1'b0;
                if (m0.a_valid || m1.a_valid) state_d = ADDR;
            end
            ADDR: begin
                s.a_valid   = sel_a_valid;
                s.a_opcode  = sel_a_opcode;
                s.a_size    = sel_a_size;
                s.a_source  = sel_a_source;
                s.a_address = sel_a_address;
                s.a_data    = sel_a_data;
                s.a_mask    = sel_a_mask;
                s.a_corrupt = sel_a_corrupt;
                gnt_a_ready = s.a_ready;
                if (sel_a_valid && s.a_ready) begin
                    cap_op_d   = sel_a_opcode;
                    cap_size_d = sel_a_size;
                    cap_src_d  = sel_a_source;
                    cnt_d      = '0;
                    state_d    = DATA;
                end else if (!sel_a_valid) begin
                    // Master withdrew its request; abandon without touching priority
                    state_d = IDLE;
                end
            end
            DATA: begin
                rsp_valid  = s.d_valid;
                rsp_op     = s.d_opcode;
                rsp_size   = s.d_size;
                rsp_src    = s.d_source;
                rsp_data   = s.d_data;
                rsp_denied = s.d_denied;
                s.d_ready  = sel_d_ready;
                if (s.d_valid && sel_d_ready) begin
                    p_d     = ~g_q;
                    state_d = IDLE;
                end else if (!s.d_valid) begin
                    // Watchdog only runs while the slave is silent
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) state_d = TOUT;
                end
            end
            TOUT: begin
                rsp_valid  = 1'b1;
                rsp_denied = 1'b1;
                rsp_size   = cap_size_q;
                rsp_src    = cap_src_q;
                rsp_op     = (cap_op_q == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                if (sel_d_ready) begin
                    p_d     = ~g_q;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Swallow the slave's late beat so it cannot reach the next requester
                s.d_ready = 1'b1;
                if (s.d_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp0 = rsp_valid & ~g_q;
        rsp1 = rsp_valid &  g_q;

        m0.a_ready  = gnt_a_ready & ~g_q;
        m0.d_valid  = rsp0;
        m0.d_opcode = rsp0 ? rsp_op     : '0;
        m0.d_size   = rsp0 ? rsp_size   : '0;
        m0.d_source = rsp0 ? rsp_src    : '0;
        m0.d_data   = rsp0 ? rsp_data   : '0;
        m0.d_denied = rsp0 ? rsp_denied : 1'b0;

        m1.a_ready  = gnt_a_ready & g_q;
        m1.d_valid  = rsp1;
        m1.d_opcode = rsp1 ? rsp_op     : '0;
        m1.d_size   = rsp1 ? rsp_size   : '0;
        m1.d_source = rsp1 ? rsp_src    : '0;
        m1.d_data   = rsp1 ? rsp_data   : '0;
        m1.d_denied = rsp1 ? rsp_denied : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= 1'b0;
            p_q        <= 1'b0;
            cnt_q      <= '0;
            cap_op_q   <= '0;
            cap_size_q <= '0;
            cap_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            cap_op_q   <= cap_op_d;
            cap_size_q <= cap_size_d;
            cap_src_q  <= cap_src_d;
        end
    end
endmodule

// File: tb/tb_tl_arb2.sv
// Directed bench for tl_arb2: a vector table of single transactions plus hand-written
// timeout/drain, master back-pressure and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_tl_arb2;
  localparam int TO = 8, CW = 4, AW = 32, DW = 64, SRCW = 4;
  localparam logic [2:0] GET = 3'd4, PUTF = 3'd0, ACK = 3'd0, ACKD = 3'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_arb2_if #(.AW(AW), .DW(DW), .SRCW(SRCW)) m0 ();
  tl_arb2_if #(.AW(AW), .DW(DW), .SRCW(SRCW)) m1 ();
  tl_arb2_if #(.AW(AW), .DW(DW), .SRCW(SRCW)) s ();

  tl_arb2 #(.TIMEOUT(TO), .CW(CW), .AW(AW), .DW(DW), .SRCW(SRCW)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s)
  );

  typedef struct {
    logic [1:0]  req;      // masters raising a_valid at the start of the entry
    int          ar_wait;  // cycles the slave holds a_ready low in ADDR
    int          lat;      // DATA cycles before the slave's d_valid
    logic        gnt;      // expected granted master
    logic [63:0] sdata;    // slave response data
    logic [2:0]  e_op;
    logic [2:0]  e_size;
    logic [3:0]  e_src;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [10];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk($sformatf("%s_vr", nm),
        {s.a_valid, s.d_ready, m0.a_ready, m1.a_ready, m0.d_valid, m1.d_valid}, 64'd0);
    chk($sformatf("%s_dz", nm),
        m0.d_data | m1.d_data | {m0.d_denied, m0.d_opcode, m0.d_size, m0.d_source,
                                 m1.d_denied, m1.d_opcode, m1.d_size, m1.d_source}, 64'd0);
  endtask

  // Entry starts in an IDLE cycle, just after a clock edge; ends just after the D handshake edge.
  task automatic run_entry(input string tag, input vec_t v);
    logic [2:0] cop, csz;
    logic [3:0] csrc;
    logic [1:0] gmask;
    gmask = v.gnt ? 2'b10 : 2'b01;
    cop = '0; csz = '0; csrc = '0;
    if (v.req[0]) m0.a_valid = 1'b1;
    if (v.req[1]) m1.a_valid = 1'b1;
    s.a_ready = (v.ar_wait == 0);
    @(negedge clk);
    chk($sformatf("%s_bubble", tag), {s.a_valid, m0.a_ready, m1.a_ready}, 64'd0);
    @(posedge clk); #1;
    for (int w = 0; w <= v.ar_wait; w++) begin
      @(negedge clk);
      chk($sformatf("%s_a_valid%0d", tag, w), s.a_valid, 64'd1);
      chk($sformatf("%s_a_addr%0d", tag, w), s.a_address, v.e_addr);
      chk($sformatf("%s_a_ready%0d", tag, w), {m1.a_ready, m0.a_ready},
          (w == v.ar_wait) ? gmask : 2'b00);
      cop = s.a_opcode; csz = s.a_size; csrc = s.a_source;
      @(posedge clk); #1;
      s.a_ready = (w + 1 == v.ar_wait);
    end
    if (v.gnt) m1.a_valid = 1'b0; else m0.a_valid = 1'b0;
    s.a_ready = 1'b0;
    for (int k = 0; k <= v.lat; k++) begin
      if (k == v.lat) begin
        s.d_valid = 1'b1; s.d_data = v.sdata; s.d_denied = 1'b0;
        s.d_opcode = (cop == GET) ? ACKD : ACK; s.d_size = csz; s.d_source = csrc;
      end else begin
        // junk on the bus while d_valid is low must not leak to either master
        s.d_valid = 1'b0; s.d_data = 64'hBADBAD00_00000000 | 64'(k); s.d_denied = 1'b1;
        s.d_opcode = 3'd7; s.d_size = 3'd7; s.d_source = '1;
      end
      @(negedge clk);
      if (k < v.lat) begin
        chk($sformatf("%s_wait%0d", tag, k), {m1.d_valid, m0.d_valid, m0.d_denied, m1.d_denied}, 64'd0);
        chk($sformatf("%s_waitdata%0d", tag, k), m0.d_data | m1.d_data, 64'd0);
      end else begin
        chk($sformatf("%s_d_valid", tag), {m1.d_valid, m0.d_valid}, gmask);
        chk($sformatf("%s_d_data", tag), v.gnt ? m1.d_data : m0.d_data, v.sdata);
        chk($sformatf("%s_d_fields", tag),
            v.gnt ? {m1.d_denied, m1.d_opcode, m1.d_size, m1.d_source}
                  : {m0.d_denied, m0.d_opcode, m0.d_size, m0.d_source},
            {1'b0, v.e_op, v.e_size, v.e_src});
        chk($sformatf("%s_s_d_ready", tag), s.d_ready, 64'd1);
      end
      @(posedge clk); #1;
    end
    s.d_valid = 1'b0; s.d_data = '0; s.d_denied = 1'b0;
    s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    m0.a_valid = 0; m0.a_opcode = GET;  m0.a_size = 3'd3; m0.a_source = 4'd2;
    m0.a_address = 32'h10; m0.a_data = '0; m0.a_mask = 8'hFF; m0.a_corrupt = 0; m0.d_ready = 1;
    m1.a_valid = 0; m1.a_opcode = PUTF; m1.a_size = 3'd2; m1.a_source = 4'd5;
    m1.a_address = 32'h20; m1.a_data = 64'h1111_2222_3333_4444; m1.a_mask = 8'h0F;
    m1.a_corrupt = 0; m1.d_ready = 1;
    s.a_ready = 0; s.d_valid = 0; s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
    s.d_data = '0; s.d_denied = 0;

    //           req   arw lat gnt sdata                    op    size  src   addr
    tbl[0] = '{2'b11, 0, 0, 1'b0, 64'hDEADBEEF_CAFEF00D, ACKD, 3'd3, 4'd2, 32'h10};
    tbl[1] = '{2'b00, 1, 2, 1'b1, 64'h01234567_89ABCDEF, ACK,  3'd2, 4'd5, 32'h20};
    tbl[2] = '{2'b11, 0, 1, 1'b0, 64'h11111111_22222222, ACKD, 3'd3, 4'd2, 32'h10};
    tbl[3] = '{2'b11, 0, 7, 1'b1, 64'h33333333_44444444, ACK,  3'd2, 4'd5, 32'h20};
    tbl[4] = '{2'b11, 2, 0, 1'b0, 64'h55555555_66666666, ACKD, 3'd3, 4'd2, 32'h10};
    tbl[5] = '{2'b11, 0, 3, 1'b1, 64'h77777777_88888888, ACK,  3'd2, 4'd5, 32'h20};
    tbl[6] = '{2'b11, 0, 0, 1'b0, 64'h99999999_AAAAAAAA, ACKD, 3'd3, 4'd2, 32'h10};
    tbl[7] = '{2'b11, 1, 5, 1'b1, 64'hBBBBBBBB_CCCCCCCC, ACK,  3'd2, 4'd5, 32'h20};
    tbl[8] = '{2'b00, 0, 7, 1'b0, 64'hDDDDDDDD_EEEEEEEE, ACKD, 3'd3, 4'd2, 32'h10};
    tbl[9] = '{2'b10, 0, 0, 1'b1, 64'h0F0F0F0F_F0F0F0F0, ACK,  3'd2, 4'd5, 32'h20};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_entry($sformatf("vec%0d", i), tbl[i]);

    // Slave never answers: denied beat after TO DATA cycles, then late beat drained
    m0.a_valid = 1'b1; s.a_ready = 1'b1;
    @(negedge clk); chk("to_bubble", s.a_valid, 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("to_addr", {s.a_valid, s.a_address}, {1'b1, 32'h10});
    @(posedge clk); #1;
    m0.a_valid = 1'b0; s.a_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk($sformatf("to_wait%0d", k), {m1.d_valid, m0.d_valid}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_d_valid", {m1.d_valid, m0.d_valid, s.d_ready}, 3'b010);
    chk("to_d_data", m0.d_data, 64'd0);
    chk("to_d_fields", {m0.d_denied, m0.d_opcode, m0.d_size, m0.d_source},
        {1'b1, ACKD, 3'd3, 4'd2});
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk($sformatf("drain_idle%0d", k), {s.d_ready, m1.d_valid, m0.d_valid}, 3'b100);
      @(posedge clk); #1;
    end
    s.d_valid = 1'b1; s.d_data = 64'hFEEDFACE_0BADF00D; s.d_opcode = ACKD;
    s.d_size = 3'd3; s.d_source = 4'd2;
    @(negedge clk); chk("drain_beat", {s.d_ready, m1.d_valid, m0.d_valid}, 3'b100);
    @(posedge clk); #1;
    s.d_valid = 1'b0; s.d_data = '0; s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
    v = '{2'b10, 0, 1, 1'b1, 64'hA5A5A5A5_5A5A5A5A, ACK, 3'd2, 4'd5, 32'h20};
    run_entry("after_drain", v);

    // m1 back-pressures a presented beat for 5 cycles, past what the watchdog would allow
    m1.a_valid = 1'b1; s.a_ready = 1'b1;
    @(negedge clk); chk("bp_bubble", s.a_valid, 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_addr", {s.a_valid, s.a_address}, {1'b1, 32'h20});
    @(posedge clk); #1;
    m1.a_valid = 1'b0; s.a_ready = 1'b0; m1.d_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("bp_wait%0d", k), {m1.d_valid, m0.d_valid}, 64'd0);
      @(posedge clk); #1;
    end
    s.d_valid = 1'b1; s.d_data = 64'hC0FFEE00_12345678; s.d_opcode = ACK;
    s.d_size = 3'd2; s.d_source = 4'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d", k), {s.d_ready, m1.d_valid, m0.d_valid, m1.d_denied}, 4'b0100);
      @(posedge clk); #1;
    end
    m1.d_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {s.d_ready, m1.d_valid, m1.d_denied}, 3'b110);
    chk("bp_data", m1.d_data, 64'hC0FFEE00_12345678);
    @(posedge clk); #1;
    s.d_valid = 1'b0; s.d_data = '0; s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
    @(negedge clk); chk("bp_done", {s.d_ready, m1.d_valid}, 64'd0);
    @(posedge clk); #1;

    // m0 completes so the pointer favours m1, then reset lands mid-DATA of an m1 request
    v = '{2'b01, 0, 0, 1'b0, 64'h13579BDF_2468ACE0, ACKD, 3'd3, 4'd2, 32'h10};
    run_entry("pre_rst", v);
    m1.a_valid = 1'b1; s.a_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_addr", {s.a_valid, s.a_address}, {1'b1, 32'h20});
    @(posedge clk); #1;
    m1.a_valid = 1'b0; s.a_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s.d_valid = 1'b1; s.d_data = 64'hBEEFBEEF_BEEFBEEF; s.d_opcode = ACK;
    s.d_size = 3'd2; s.d_source = 4'd5;
    @(negedge clk);
    chk_quiet("rst_mid");
    @(posedge clk); #1;
    s.d_valid = 1'b0; s.d_data = '0; s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
    v = '{2'b11, 0, 0, 1'b0, 64'h2222AAAA_3333BBBB, ACKD, 3'd3, 4'd2, 32'h10};
    run_entry("post_rst0", v);
    v = '{2'b00, 0, 2, 1'b1, 64'h4444CCCC_5555DDDD, ACK, 3'd2, 4'd5, 32'h20};
    run_entry("post_rst1", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
